// File: rtl/int_pkg.sv
// Shared constants and types for the interrupt pending register and the interrupt controller.
// Device-id width here must agree with the controller's id width.
package int_pkg;

  localparam int DEV_ID_SIZE_DEF = 8;

  function automatic int dev_ids(input int id_size);
    return 1 << id_size;
  endfunction

  localparam int DEV_IDS_DEF = dev_ids(DEV_ID_SIZE_DEF);

  typedef logic [DEV_ID_SIZE_DEF-1:0] dev_id_t;

endpackage

// File: rtl/int_pending_if.sv
// CPU/device-side bundle of the interrupt pending register.
// Handshake: mask_we and ack are single-cycle strobes with no back-pressure; each asserted
// cycle takes effect at that rising edge, and the registered outputs reflect it right after.
interface int_pending_if #(
  parameter int DEV_ID_SIZE = int_pkg::DEV_ID_SIZE_DEF
) ();
  localparam int DEV_IDS = int_pkg::dev_ids(DEV_ID_SIZE);

  logic [DEV_IDS-1:0]     irq;
  logic                   mask_we;
  logic [DEV_IDS-1:0]     mask_wdata;
  logic                   ack;
  logic [DEV_ID_SIZE-1:0] ack_id;
  logic [DEV_IDS-1:0]     ints;
  logic                   any;
  logic [DEV_IDS-1:0]     mask;
  logic [DEV_IDS-1:0]     overrun;
  logic [DEV_IDS-1:0]     pending;

  modport master (
    output irq, mask_we, mask_wdata, ack, ack_id,
    input  ints, any, mask, overrun, pending
  );

  modport slave (
    input  irq, mask_we, mask_wdata, ack, ack_id,
    output ints, any, mask, overrun, pending
  );
endinterface

// File: rtl/int_sync.sv
// Two-flop synchroniser, synchronous reset to all ones so lines idling high after reset
// do not look like fresh rising edges downstream.
module int_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/int_pending.sv
// Sticky, maskable interrupt pending bits with per-device overrun flags feeding the controller.
// Define INT_SYNC_EN to pass irq through a two-flop synchroniser before edge detection.
module int_pending
  import int_pkg::*;
#(
  parameter int DEV_ID_SIZE = DEV_ID_SIZE_DEF
) (
  input  logic         clk,
  input  logic         rst,
  int_pending_if.slave bus
);
  localparam int DEV_IDS = dev_ids(DEV_ID_SIZE);

  logic [DEV_IDS-1:0] w_irq;
  logic [DEV_IDS-1:0] w_rise;
  logic [DEV_IDS-1:0] w_clr;
  logic [DEV_IDS-1:0] w_pending_n;
  logic [DEV_IDS-1:0] w_overrun_n;
  logic [DEV_IDS-1:0] w_mask_n;
  logic [DEV_IDS-1:0] w_ints_n;

  logic [DEV_IDS-1:0] r_prev_irq;
  logic [DEV_IDS-1:0] r_pending;
  logic [DEV_IDS-1:0] r_overrun;
  logic [DEV_IDS-1:0] r_mask;
  logic [DEV_IDS-1:0] r_ints;
  logic               r_any;

`ifdef INT_SYNC_EN
  int_sync #(
    .WIDTH (DEV_IDS)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.irq),
    .o_q (w_irq)
  );
`else
  assign w_irq = bus.irq;
`endif

  // A set and an ack on the same id in one cycle keep the new request; the ack still
  // suppresses overrun detection for that id.
  always_comb begin
    w_rise      = w_irq & ~r_prev_irq;
    w_clr       = '0;
    if (bus.ack) begin
      w_clr[bus.ack_id] = 1'b1;
    end
    w_pending_n = (r_pending & ~w_clr) | w_rise;
    w_overrun_n = (r_overrun & ~w_clr) | (w_rise & r_pending & ~w_clr);
    w_mask_n    = bus.mask_we ? bus.mask_wdata : r_mask;
    w_ints_n    = w_pending_n & w_mask_n;
  end

  // prev_irq resets to ones so lines already high at reset release stay quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_irq <= '1;
      r_pending  <= '0;
      r_overrun  <= '0;
      r_mask     <= '0;
      r_ints     <= '0;
      r_any      <= 1'b0;
    end else begin
      r_prev_irq <= w_irq;
      r_pending  <= w_pending_n;
      r_overrun  <= w_overrun_n;
      r_mask     <= w_mask_n;
      r_ints     <= w_ints_n;
      r_any      <= |w_ints_n;
    end
  end

  assign bus.ints    = r_ints;
  assign bus.any     = r_any;
  assign bus.mask    = r_mask;
  assign bus.overrun = r_overrun;
  assign bus.pending = r_pending;
endmodule
